// File: rtl/serial_pkg.sv
// Shared types and constants for the processor-to-UART serial bridge.
package serial_pkg;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

  assign tick = (count == '0);
endmodule

// File: rtl/serial_bridge.sv
// 8N1 UART bridge between the processor's byte-wide serial port and a pin pair.
module serial_bridge
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wren,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rden,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int unsigned     CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- transmitter ----------------
  tx_state_t  tx_state;
  logic [7:0] tx_shift;
  logic [2:0] tx_bit;
  logic       tx_load;
  logic       tx_tick;

  always_comb begin
    tx_load = 1'b0;
    if (tx_state == TX_IDLE)
      tx_load = tx_wren;
    else if (tx_state != TX_STOP)
      tx_load = tx_tick;
  end

  uart_bit_timer #(.WIDTH(CW)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .load_val (BIT_LOAD),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      uart_txd <= 1'b1;
      tx_ready <= 1'b1;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_wren) begin
          tx_shift <= tx_data;
          uart_txd <= 1'b0;
          tx_ready <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_tick) begin
          uart_txd <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            uart_txd <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end
        TX_STOP: if (tx_tick) begin
          tx_ready <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t    rx_state;
  logic         rxd_meta;
  logic         rxd_sync;
  logic [7:0]   rx_shift;
  logic [2:0]   rx_bit;
  logic         rx_hold;
  logic         rx_load;
  logic         rx_tick;
  logic [CW-1:0] rx_load_val;

  // Start edge arms a half-bit wait so every later sample lands mid-bit.
  always_comb begin
    rx_load     = 1'b0;
    rx_load_val = BIT_LOAD;
    case (rx_state)
      RX_IDLE: begin
        rx_load     = !rxd_sync;
        rx_load_val = HALF_LOAD;
      end
      RX_START: rx_load = rx_tick && !rxd_sync;
      RX_DATA:  rx_load = rx_tick;
      default:  rx_load = 1'b0;
    endcase
  end

  uart_bit_timer #(.WIDTH(CW)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta     <= 1'b1;
      rxd_sync     <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_hold      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rxd_meta     <= uart_rxd;
      rxd_sync     <= rxd_meta;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_rden && rx_valid)
        rx_valid <= 1'b0;

      case (rx_state)
        RX_IDLE: if (!rxd_sync) rx_state <= RX_START;
        RX_START: if (rx_tick) begin
          if (!rxd_sync) begin
            rx_bit   <= '0;
            rx_state <= RX_DATA;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_DATA: if (rx_tick) begin
          rx_shift <= {rxd_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7)
            rx_state <= RX_STOP;
          else
            rx_bit <= rx_bit + 3'd1;
        end
        RX_STOP: begin
          // After a framing error the timer idles at zero, so rx_hold gates re-reporting.
          if (rx_hold) begin
            if (rxd_sync) begin
              rx_hold  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_tick) begin
            if (rxd_sync) begin
              rx_state <= RX_IDLE;
              if (rx_valid && !rx_rden) begin
                rx_overrun <= 1'b1;
              end else begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end else begin
              rx_frame_err <= 1'b1;
              rx_hold      <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/serial_bridge.md
SERIAL_BRIDGE -- requirements
Module: serial_bridge

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port tx_data, input, 8, byte from the processor's serial_out.
REQ-005 The block SHALL have port tx_wren, input, 1, byte-write strobe from the processor's serial_wren_out.
REQ-006 The block SHALL have port tx_ready, output, 1, transmit buffer empty; drives the processor's serial_ready_in.
REQ-007 The block SHALL have port rx_data, output, 8, received byte; drives the processor's serial_in.
REQ-008 The block SHALL have port rx_valid, output, 1, rx_data holds an unread byte; drives the processor's serial_valid_in.
REQ-009 The block SHALL have port rx_rden, input, 1, byte-consume strobe from the processor's serial_rden_out.
REQ-010 The block SHALL have port uart_rxd, input, 1, asynchronous serial line in; idles high.
REQ-011 The block SHALL have port uart_txd, output, 1, serial line out; idles high.
REQ-012 The block SHALL have port rx_overrun, output, 1, one-cycle pulse when a received byte is dropped.
REQ-013 The block SHALL have port rx_frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-015 The TX FSM SHALL have states IDLE, START, DATA, STOP; tx_ready is 1 only in IDLE.
REQ-016 tx_wren with tx_ready=1 in cycle N SHALL latch tx_data, drop tx_ready at N+1, and drive uart_txd=0 (START) from N+1.
REQ-017 tx_wren with tx_ready=0 SHALL be ignored, with no effect on the frame in flight.
REQ-018 After the STOP bit's CLKS_PER_BIT cycles, TX SHALL return to IDLE with tx_ready=1; a back-to-back tx_wren in that cycle SHALL start the next frame with no extra idle bit.
REQ-019 uart_rxd SHALL pass a 2-flop synchronizer before any use; the 2-cycle latency is accepted.
REQ-020 The RX FSM SHALL have states IDLE, START, DATA, STOP, transitioning as follows.
- IDLE: on a synchronized low, go to START.
- START: wait CLKS_PER_BIT/2 cycles; if the line is still low, go to DATA, else return to IDLE (glitch rejection).
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
- STOP: sample at mid-bit.
REQ-021 A stop sample of 1 SHALL deliver the byte, setting rx_valid=1 and rx_data=byte in the next cycle.
REQ-022 A stop sample of 0 SHALL discard the byte, pulse rx_frame_err, and move to IDLE only once the line returns high.
REQ-023 rx_data SHALL remain stable while rx_valid=1.
REQ-024 rx_rden with rx_valid=1 SHALL clear rx_valid in the next cycle; rx_rden with rx_valid=0 SHALL be ignored.
REQ-025 Delivery while rx_valid=1 and no rx_rden in that cycle SHALL keep the old byte, drop the new one, and pulse rx_overrun.
REQ-026 Delivery and rx_rden in the same cycle SHALL consume the old byte and load the new one, keeping rx_valid=1 with no overrun.
REQ-027 Bit counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary, with no off-by-one accumulation across a frame.

Reset
REQ-028 When reset=1 at a clock edge, the following state SHALL take effect in the next cycle:
- uart_txd=1, tx_ready=1, rx_valid=0, rx_data=0x00;
- rx_overrun=0, rx_frame_err=0;
- both FSMs in IDLE with counters at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with no partial byte delivered and no error pulse.

Structure
REQ-030 The shared package serial_pkg SHALL hold the TX and RX state enums, the frame length constant (10 bits), and the default CLKS_PER_BIT.
REQ-031 A single sub-module, uart_bit_timer (a loadable down-counter with a tick output), SHALL be instantiated once in TX and once in RX.

Verification (CLKS_PER_BIT=4)
REQ-032 Reset test: assert reset for 2 cycles, then release -> uart_txd=1, tx_ready=1, rx_valid=0, rx_data=0x00.
REQ-033 TX test: tx_wren with 0xA5 -> tx_ready=0 next cycle; uart_txd emits 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; tx_ready=1 forty cycles after the first START cycle.
REQ-034 RX test: drive frame 0x3C on uart_rxd -> rx_valid=1 with rx_data=0x3C; then rx_rden -> rx_valid=0 the following cycle.
REQ-035 Overrun test: drive frames 0x11 then 0x22 with no rx_rden -> rx_data stays 0x11 and rx_overrun pulses exactly once.
REQ-036 Framing test: drive a frame with its stop bit 0 -> rx_valid stays 0 and rx_frame_err pulses once.
REQ-037 Glitch and abort test:
- a 1-cycle low on uart_rxd -> no delivery;
- reset asserted mid-TX-frame -> uart_txd=1 and tx_ready=1 the next cycle.
